// File: rtl/fp_mul_unpack_pipe_if.sv
// Operand/result bundle for fp_mul_unpack_pipe. exp_sat exists only when FP_MUL_SAT_EN is defined.
interface fp_mul_unpack_pipe_if;
    logic        valid;
    logic [30:0] float_in_a;
    logic [30:0] float_in_b;
    logic [30:0] float_in_2;
    logic [47:0] M_out_mul;
    logic [7:0]  E_out_mul;
    logic [30:0] float_out_2;
    logic        ready;
`ifdef FP_MUL_SAT_EN
    logic        exp_sat;

    modport master (
        output valid, float_in_a, float_in_b, float_in_2,
        input  M_out_mul, E_out_mul, float_out_2, ready, exp_sat
    );
    modport slave (
        input  valid, float_in_a, float_in_b, float_in_2,
        output M_out_mul, E_out_mul, float_out_2, ready, exp_sat
    );
`else
    modport master (
        output valid, float_in_a, float_in_b, float_in_2,
        input  M_out_mul, E_out_mul, float_out_2, ready
    );
    modport slave (
        input  valid, float_in_a, float_in_b, float_in_2,
        output M_out_mul, E_out_mul, float_out_2, ready
    );
`endif
endinterface

// File: rtl/fp_mul_unpack_pipe.sv
// Unpack two sign-less floats, form the exact 24x24 mantissa product and unbiased exponent sum.
// Optional FP_MUL_SAT_EN clamps the exponent to [-126,127] and reports it on exp_sat.
module fp_mul_unpack_pipe #(
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_mul_unpack_pipe_if.slave   bus
);

    typedef struct packed {
        logic [23:0]       ma;
        logic [23:0]       mb;
        logic signed [9:0] esum;
        logic              zero;
        logic [30:0]       side;
        logic              vld;
    } unp_t;

    typedef struct packed {
        logic [35:0]       pp_lo;
        logic [35:0]       pp_hi;
        logic signed [9:0] esum;
        logic              zero;
        logic [30:0]       side;
        logic              vld;
    } prod_t;

    // Product split on operand B: low 12 bits and high 12 bits, recombined at the output stage.
    function automatic prod_t split_mul(input unp_t u);
        prod_t p;
        p.pp_lo = {12'b0, u.ma} * {24'b0, u.mb[11:0]};
        p.pp_hi = {12'b0, u.ma} * {24'b0, u.mb[23:12]};
        p.esum  = u.esum;
        p.zero  = u.zero;
        p.side  = u.side;
        p.vld   = u.vld;
        return p;
    endfunction

    function automatic logic [7:0] exp_out(input logic signed [9:0] s, input logic z);
        if (z) return 8'h00;
`ifdef FP_MUL_SAT_EN
        if (s > 10'sd127)  return 8'h7F;
        if (s < -10'sd126) return 8'h82;
`endif
        return s[7:0];
    endfunction

`ifdef FP_MUL_SAT_EN
    function automatic logic exp_clamped(input logic signed [9:0] s, input logic z);
        return !z && ((s > 10'sd127) || (s < -10'sd126));
    endfunction
`endif

    unp_t  unp_d;
    prod_t tail;

    always_comb begin
        unp_d      = '0;
        unp_d.ma   = {1'b1, bus.float_in_a[22:0]};
        unp_d.mb   = {1'b1, bus.float_in_b[22:0]};
        unp_d.esum = $signed({2'b00, bus.float_in_a[30:23]})
                   + $signed({2'b00, bus.float_in_b[30:23]}) - 10'sd254;
        unp_d.zero = (bus.float_in_a[30:23] == 8'h00) || (bus.float_in_b[30:23] == 8'h00);
        unp_d.side = bus.float_in_2;
        unp_d.vld  = bus.valid;
    end

    if (PIPE_STAGES == 1) begin : g_direct
        assign tail = split_mul(unp_d);
    end else begin : g_staged
        // Stage 1: unpacked mantissas, exponent sum, side operand
        unp_t unp_p1_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) unp_p1_q <= '0;
            else     unp_p1_q <= unp_d;
        end

        if (PIPE_STAGES == 2) begin : g_two
            assign tail = split_mul(unp_p1_q);
        end else begin : g_deep
            // Stage 2: registered partial products; later stages only delay them
            prod_t pp_p2_q [PIPE_STAGES-2];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_STAGES-2; i++) pp_p2_q[i] <= '0;
                end else begin
                    pp_p2_q[0] <= split_mul(unp_p1_q);
                    for (int i = 1; i < PIPE_STAGES-2; i++) pp_p2_q[i] <= pp_p2_q[i-1];
                end
            end
            assign tail = pp_p2_q[PIPE_STAGES-3];
        end
    end

    logic [47:0] m_d, m_q;
    logic [7:0]  e_d, e_q;
    logic [30:0] side_q;
    logic        rdy_q;
`ifdef FP_MUL_SAT_EN
    logic        sat_d, sat_q;
`endif

    always_comb begin
        m_d = tail.zero ? 48'h0 : ({12'b0, tail.pp_lo} + {tail.pp_hi, 12'b0});
        e_d = exp_out(tail.esum, tail.zero);
`ifdef FP_MUL_SAT_EN
        sat_d = exp_clamped(tail.esum, tail.zero);
`endif
    end

    // Final stage: outputs load only on a live tag, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            e_q    <= '0;
            side_q <= '0;
            rdy_q  <= 1'b0;
`ifdef FP_MUL_SAT_EN
            sat_q  <= 1'b0;
`endif
        end else begin
            rdy_q <= tail.vld;
            if (tail.vld) begin
                m_q    <= m_d;
                e_q    <= e_d;
                side_q <= tail.side;
`ifdef FP_MUL_SAT_EN
                sat_q  <= sat_d;
`endif
            end
        end
    end

    assign bus.M_out_mul   = m_q;
    assign bus.E_out_mul   = e_q;
    assign bus.float_out_2 = side_q;
    assign bus.ready       = rdy_q;
`ifdef FP_MUL_SAT_EN
    assign bus.exp_sat     = sat_q;
`endif

endmodule

// File: tb/tb_fp_mul_unpack_pipe.sv
// Scoreboard bench for fp_mul_unpack_pipe: directed vectors, monitor pops expectations on ready.
module tb_fp_mul_unpack_pipe;
    localparam int PIPE_STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        logic [47:0] m;
        logic [7:0]  e;
        logic [30:0] s;
        logic        sat;
        int          stamp;
    } exp_t;

    exp_t sb[$];

    fp_mul_unpack_pipe_if bus();

    fp_mul_unpack_pipe #(.PIPE_STAGES(PIPE_STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Issue one valid transaction and record the hand-computed response.
    task automatic send(input logic [30:0] a, input logic [30:0] b, input logic [30:0] s,
                        input logic [47:0] m, input logic [7:0] e_wrap,
                        input logic [7:0] e_sat, input logic sat);
        exp_t t;
        @(negedge clk);
        bus.valid      = 1'b1;
        bus.float_in_a = a;
        bus.float_in_b = b;
        bus.float_in_2 = s;
        t.m     = m;
`ifdef FP_MUL_SAT_EN
        t.e     = e_sat;
        t.sat   = sat;
`else
        t.e     = e_wrap;
        t.sat   = 1'b0;
`endif
        t.s     = s;
        t.stamp = cyc;
        sb.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.valid      = 1'b0;
            bus.float_in_a = 31'($urandom);
            bus.float_in_b = 31'($urandom);
            bus.float_in_2 = 31'($urandom);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t t;
        if (!rst && bus.ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(bus.ready), 64'd0);
            end else begin
                t = sb.pop_front();
                chk("M_out_mul", 64'(bus.M_out_mul), 64'(t.m));
                chk("E_out_mul", 64'(bus.E_out_mul), 64'(t.e));
                chk("float_out_2", 64'(bus.float_out_2), 64'(t.s));
                chk("latency", 64'(cyc - t.stamp), 64'(PIPE_STAGES));
`ifdef FP_MUL_SAT_EN
                chk("exp_sat", 64'(bus.exp_sat), 64'(t.sat));
`endif
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd0);
        chk({tag, "_M"}, 64'(bus.M_out_mul), 64'd0);
        chk({tag, "_E"}, 64'(bus.E_out_mul), 64'd0);
        chk({tag, "_side"}, 64'(bus.float_out_2), 64'd0);
`ifdef FP_MUL_SAT_EN
        chk({tag, "_sat"}, 64'(bus.exp_sat), 64'd0);
`endif
    endtask

    initial begin
        int waited;
        bus.valid      = 1'b0;
        bus.float_in_a = '0;
        bus.float_in_b = '0;
        bus.float_in_2 = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        send(31'h3F800000, 31'h3F800000, 31'h00000001, 48'h4000_0000_0000, 8'h00, 8'h00, 1'b0);
        idle(1);
        send(31'h40000000, 31'h40400000, 31'h00000002, 48'h6000_0000_0000, 8'h02, 8'h02, 1'b0);
        send(31'h3FC00000, 31'h3FC00000, 31'h12345678, 48'h9000_0000_0000, 8'h00, 8'h00, 1'b0);
        send(31'h00000000, 31'h3F800000, 31'h00000004, 48'h0,              8'h00, 8'h00, 1'b0);
        idle(3);

        // Four back-to-back operands
        send(31'h3F800000, 31'h40000000, 31'h0000000A, 48'h4000_0000_0000, 8'h01, 8'h01, 1'b0);
        send(31'h40400000, 31'h40400000, 31'h0000000B, 48'h9000_0000_0000, 8'h02, 8'h02, 1'b0);
        send(31'h3F800001, 31'h3F800000, 31'h0000000C, 48'h4000_0080_0000, 8'h00, 8'h00, 1'b0);
        send(31'h3FFFFFFF, 31'h3FFFFFFF, 31'h0000000D, 48'hFFFF_FE00_0001, 8'h00, 8'h00, 1'b0);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ready", 64'(bus.ready), 64'd0);
            chk("hold_M", 64'(bus.M_out_mul), 64'hFFFF_FE00_0001);
            chk("hold_side", 64'(bus.float_out_2), 64'h0000000D);
        end

        // Exponent extremes and flush with a large partner exponent
        send(31'h7F000000, 31'h7F000000, 31'h00000020, 48'h4000_0000_0000, 8'hFE, 8'h7F, 1'b1);
        send(31'h00800000, 31'h00800000, 31'h00000021, 48'h4000_0000_0000, 8'h04, 8'h82, 1'b1);
        send(31'h7F000000, 31'h00000000, 31'h00000022, 48'h0,              8'h00, 8'h00, 1'b0);
        send(31'h3F800000, 31'h3F800000, 31'h00000023, 48'h4000_0000_0000, 8'h00, 8'h00, 1'b0);
        idle(5);

        // Operand in flight when reset hits is dropped
        @(negedge clk);
        bus.valid      = 1'b1;
        bus.float_in_a = 31'h40000000;
        bus.float_in_b = 31'h40400000;
        bus.float_in_2 = 31'h0BADBEEF;
        @(negedge clk);
        bus.valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero_outputs("midreset");
        end
        rst = 1'b0;
        send(31'h40000000, 31'h40400000, 31'h00000030, 48'h6000_0000_0000, 8'h02, 8'h02, 1'b0);
        idle(1);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
